// File: rtl/scan_pkg.sv
// Shared types and default widths for the RAM scan reader.
// The optional continuous-refresh mode is selected with SCAN_LOOP_EN.
package scan_pkg;

    localparam int SCAN_ADDR_WIDTH = 9;
    localparam int SCAN_WORD_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/word_serializer.sv
// Parallel-in/serial-out word shifter, LSB first, with valid/ready handshake.
// Valid rises on load and falls when the last bit of the word is accepted.
module word_serializer
    import scan_pkg::*;
#(
    parameter int WIDTH = SCAN_WORD_WIDTH
)
(
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    output logic             o_valid,
    output logic             o_bit,
    output logic             o_last_accepted
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_valid;
    logic             w_accept;

    assign w_accept        = r_valid & i_ready;
    assign o_last_accepted = w_accept && (r_bit_cnt == LAST_BIT);
    assign o_valid         = r_valid;
    assign o_bit           = r_valid & r_shreg[0];

    // Without a handshake nothing moves, so a stalled bit is neither lost nor repeated.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_shreg   <= i_word;
            r_bit_cnt <= '0;
            r_valid   <= 1'b1;
        end else if (w_accept) begin
            r_shreg   <= {1'b0, r_shreg[WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (o_last_accepted) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ram_scan_reader.sv
// Sweeps a window of a combinational-read RAM and streams each word out bitwise.
// SCAN_LOOP_EN adds an i_stop port and continuous refresh of the window.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | waiting for i_start; base/count latched when it arrives
//  S_FETCH | ram address stable, RAM word loaded into the serializer
//  S_SHIFT | bits presented on the pixel port until the word is consumed
//  S_DONE  | one-cycle done pulse, then idle (or reload when looping)
module ram_scan_reader
    import scan_pkg::*;
#(
    parameter int ADDR_WIDTH = SCAN_ADDR_WIDTH,
    parameter int WORD_WIDTH = SCAN_WORD_WIDTH
)
(
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [ADDR_WIDTH:0]   i_count,
`ifdef SCAN_LOOP_EN
    input  logic                  i_stop,
`endif
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    input  logic [WORD_WIDTH-1:0] i_ram_data,
    output logic                  o_pix_valid,
    input  logic                  i_pix_ready,
    output logic                  o_pix_data,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [ADDR_WIDTH:0] ONE_WORD = (ADDR_WIDTH + 1)'(1);

    scan_state_t           r_state;
    scan_state_t           w_state_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_words_left;
    logic                  w_load;
    logic                  w_last_accepted;
`ifdef SCAN_LOOP_EN
    logic                  r_stop_seen;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = (i_count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: w_state_next = S_SHIFT;
            S_SHIFT: begin
                if (w_last_accepted) begin
                    w_state_next = (r_words_left == ONE_WORD) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
`ifdef SCAN_LOOP_EN
                if (!(r_stop_seen || i_stop)) begin
                    w_state_next = (r_count == '0) ? S_DONE : S_FETCH;
                end
`endif
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Address wraps naturally at the RAM size since r_addr is ADDR_WIDTH wide.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_base       <= '0;
            r_count      <= '0;
            r_addr       <= '0;
            r_words_left <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_base       <= i_base;
            r_count      <= i_count;
            r_addr       <= i_base;
            r_words_left <= i_count;
        end else if (r_state == S_SHIFT && w_last_accepted && r_words_left != ONE_WORD) begin
            r_addr       <= r_addr + 1'b1;
            r_words_left <= r_words_left - 1'b1;
        end else if (r_state == S_DONE && w_state_next == S_FETCH) begin
            r_addr       <= r_base;
            r_words_left <= r_count;
        end
    end

`ifdef SCAN_LOOP_EN
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stop_seen <= 1'b0;
        end else if (w_state_next == S_IDLE) begin
            r_stop_seen <= 1'b0;
        end else if (i_stop) begin
            r_stop_seen <= 1'b1;
        end
    end
`endif

    assign w_load = (r_state == S_FETCH);

    word_serializer #(
        .WIDTH (WORD_WIDTH)
    ) u_serializer (
        .i_clock         (i_clock),
        .i_reset_n       (i_reset_n),
        .i_load          (w_load),
        .i_word          (i_ram_data),
        .i_ready         (i_pix_ready),
        .o_valid         (o_pix_valid),
        .o_bit           (o_pix_data),
        .o_last_accepted (w_last_accepted)
    );

    assign o_ram_address = r_addr;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);

endmodule

// File: tb/tb_ram_scan_reader.sv
// Self-checking bench for ram_scan_reader: expected bits/addresses are queued
// from a bench-side RAM image and compared as the pixel port hands them over.
module tb_ram_scan_reader;

    localparam int AW = 9;
    localparam int WW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   count;
    logic          stop;
    logic [AW-1:0] ram_address;
    logic [WW-1:0] ram_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_data;
    logic          busy;
    logic          done;

    logic [WW-1:0] mem [0:511];
    assign ram_data = mem[ram_address];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          b;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ram_scan_reader dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_start       (start),
        .i_base        (base),
        .i_count       (count),
`ifdef SCAN_LOOP_EN
        .i_stop        (stop),
`endif
        .o_ram_address (ram_address),
        .i_ram_data    (ram_data),
        .o_pix_valid   (pix_valid),
        .i_pix_ready   (pix_ready),
        .o_pix_data    (pix_data),
        .o_busy        (busy),
        .o_done        (done)
    );

    task automatic push_scan(input logic [AW-1:0] b, input int c, input int passes);
        logic [AW-1:0] a;
        logic [WW-1:0] word;
        for (int p = 0; p < passes; p++) begin
            for (int w = 0; w < c; w++) begin
                a    = b + AW'(w);
                word = mem[a];
                for (int k = 0; k < WW; k++) begin
                    sb.push_back('{addr: a, b: word[k]});
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base = '0; count = '0; stop = 1'b0; pix_ready = 1'b1;
        #1;
        checks++;
        if ({ram_address, pix_valid, pix_data, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs addr=%0d valid=%b data=%b busy=%b done=%b expected all 0",
                     ram_address, pix_valid, pix_data, busy, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, pix_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle busy=%b done=%b valid=%b expected 0/0/0", busy, done, pix_valid);
        end
    endtask

    task automatic test_single_word();
        exp_t e;
        int first = -1, last = -1, nbits = 0, ndone = 0, done_cyc = -1;
        mem[5] = 16'hA5C3;
        push_scan(9'd5, 1, 1);
        base = 9'd5; count = 10'd1; pix_ready = 1'b1; start = 1'b1;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (pix_valid && pix_ready) begin
                nbits++; checks++;
                if (first < 0) first = cyc;
                last = cyc;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL single_extra_bit got=%b expected none", pix_data);
                end else begin
                    e = sb.pop_front();
                    if ({ram_address, pix_data} !== {e.addr, e.b}) begin
                        failures++;
                        $display("FAIL single_bit%0d got addr=%0d bit=%b expected addr=%0d bit=%b",
                                 nbits - 1, ram_address, pix_data, e.addr, e.b);
                    end
                end
            end
            if (done) begin ndone++; done_cyc = cyc; end
        end
        checks++;
        if (nbits != 16) begin failures++; $display("FAIL single_bit_count got=%0d expected=16", nbits); end
        checks++;
        if (first != 1) begin failures++; $display("FAIL single_first_valid got=%0d expected=1", first); end
        checks++;
        if (last != 16) begin failures++; $display("FAIL single_last_bit got=%0d expected=16", last); end
        checks++;
        if (ndone != 1) begin failures++; $display("FAIL single_done_count got=%0d expected=1", ndone); end
        checks++;
        if (done_cyc != 17) begin failures++; $display("FAIL single_done_cycle got=%0d expected=17", done_cyc); end
    endtask

    task automatic test_wrap();
        exp_t e;
        int nbits = 0, ndone = 0, done_cyc = -1, busy_errs = 0;
        push_scan(9'd510, 4, 1);
        base = 9'd510; count = 10'd4; pix_ready = 1'b1; start = 1'b1;
        for (int cyc = 0; cyc < 75; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (pix_valid && pix_ready) begin
                nbits++; checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL wrap_extra_bit got=%b expected none", pix_data);
                end else begin
                    e = sb.pop_front();
                    if ({ram_address, pix_data} !== {e.addr, e.b}) begin
                        failures++;
                        $display("FAIL wrap_bit%0d got addr=%0d bit=%b expected addr=%0d bit=%b",
                                 nbits - 1, ram_address, pix_data, e.addr, e.b);
                    end
                end
            end
            if (done) begin ndone++; done_cyc = cyc; end
            if ((cyc <= 68) != (busy === 1'b1)) busy_errs++;
        end
        checks++;
        if (nbits != 64) begin failures++; $display("FAIL wrap_bit_count got=%0d expected=64", nbits); end
        checks++;
        if (ndone != 1 || done_cyc != 68) begin
            failures++; $display("FAIL wrap_done got count=%0d cycle=%0d expected count=1 cycle=68", ndone, done_cyc);
        end
        checks++;
        if (busy_errs != 0) begin failures++; $display("FAIL wrap_busy got errors=%0d expected=0", busy_errs); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int nbits = 0, held = 0, done_cyc = -1;
        mem[0] = 16'h0001;
        push_scan(9'd0, 1, 1);
        base = 9'd0; count = 10'd1; start = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            pix_ready = !(cyc >= 1 && cyc <= 3);
            if (pix_valid && pix_data) held++;
            if (pix_valid && pix_ready) begin
                nbits++; checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL bp_extra_bit got=%b expected none", pix_data);
                end else begin
                    e = sb.pop_front();
                    if ({ram_address, pix_data} !== {e.addr, e.b}) begin
                        failures++;
                        $display("FAIL bp_bit%0d got addr=%0d bit=%b expected addr=%0d bit=%b",
                                 nbits - 1, ram_address, pix_data, e.addr, e.b);
                    end
                end
            end
            if (done) done_cyc = cyc;
        end
        pix_ready = 1'b1;
        checks++;
        if (held != 4) begin failures++; $display("FAIL bp_hold_cycles got=%0d expected=4", held); end
        checks++;
        if (nbits != 16) begin failures++; $display("FAIL bp_bit_count got=%0d expected=16", nbits); end
        checks++;
        if (done_cyc != 20) begin failures++; $display("FAIL bp_done_cycle got=%0d expected=20", done_cyc); end
    endtask

    task automatic test_count_zero_and_restart();
        exp_t e;
        int ndone = 0, done_cyc = -1, nbusy = 0, nvalid = 0, nbits = 0;
        base = 9'd9; count = 10'd0; pix_ready = 1'b1; start = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin ndone++; done_cyc = cyc; end
            if (busy) nbusy++;
            if (pix_valid) nvalid++;
        end
        checks++;
        if (ndone != 1 || done_cyc != 0) begin
            failures++; $display("FAIL zero_done got count=%0d cycle=%0d expected count=1 cycle=0", ndone, done_cyc);
        end
        checks++;
        if (nbusy != 1) begin failures++; $display("FAIL zero_busy_cycles got=%0d expected=1", nbusy); end
        checks++;
        if (nvalid != 0) begin failures++; $display("FAIL zero_valid_cycles got=%0d expected=0", nvalid); end

        ndone = 0; done_cyc = -1;
        push_scan(9'd100, 2, 1);
        base = 9'd100; count = 10'd2; start = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            start = (cyc == 5);
            if (cyc == 5) begin base = 9'd200; count = 10'd3; end
            if (pix_valid && pix_ready) begin
                nbits++; checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL restart_extra_bit got=%b expected none", pix_data);
                end else begin
                    e = sb.pop_front();
                    if ({ram_address, pix_data} !== {e.addr, e.b}) begin
                        failures++;
                        $display("FAIL restart_bit%0d got addr=%0d bit=%b expected addr=%0d bit=%b",
                                 nbits - 1, ram_address, pix_data, e.addr, e.b);
                    end
                end
            end
            if (done) begin ndone++; done_cyc = cyc; end
        end
        checks++;
        if (nbits != 32 || ndone != 1 || done_cyc != 34) begin
            failures++;
            $display("FAIL restart_ignored got bits=%0d done=%0d at %0d expected bits=32 done=1 at 34",
                     nbits, ndone, done_cyc);
        end
    endtask

    task automatic test_reset_mid_scan();
        exp_t e;
        int nbits = 0, ndone = 0, nvalid = 0, addr_errs = 0;
        push_scan(9'd20, 3, 1);
        base = 9'd20; count = 10'd3; pix_ready = 1'b1; start = 1'b1;
        for (int cyc = 0; cyc < 26; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (pix_valid && pix_ready) begin
                nbits++; checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL abort_extra_bit got=%b expected none", pix_data);
                end else begin
                    e = sb.pop_front();
                    if ({ram_address, pix_data} !== {e.addr, e.b}) begin
                        failures++;
                        $display("FAIL abort_bit%0d got addr=%0d bit=%b expected addr=%0d bit=%b",
                                 nbits - 1, ram_address, pix_data, e.addr, e.b);
                    end
                end
            end
            if (done) ndone++;
        end
        @(negedge clk);
        checks++;
        if (nbits != 24 || pix_valid !== 1'b1 || ram_address !== 9'd21) begin
            failures++;
            $display("FAIL abort_pre_reset got bits=%0d valid=%b addr=%0d expected bits=24 valid=1 addr=21",
                     nbits, pix_valid, ram_address);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_address, pix_valid, pix_data, busy, done} !== '0) begin
            failures++;
            $display("FAIL abort_async_outputs addr=%0d valid=%b data=%b busy=%b done=%b expected all 0",
                     ram_address, pix_valid, pix_data, busy, done);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (done) ndone++;
            if (pix_valid) nvalid++;
        end
        checks++;
        if (ndone != 0 || nvalid != 0) begin
            failures++; $display("FAIL abort_no_done got done=%0d valid=%0d expected 0/0", ndone, nvalid);
        end

        nbits = 0;
        mem[7] = 16'($urandom);
        push_scan(9'd7, 1, 1);
        base = 9'd7; count = 10'd1; start = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 0 && ram_address !== 9'd7) addr_errs++;
            if (pix_valid && pix_ready) begin
                nbits++; checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL clean_extra_bit got=%b expected none", pix_data);
                end else begin
                    e = sb.pop_front();
                    if ({ram_address, pix_data} !== {e.addr, e.b}) begin
                        failures++;
                        $display("FAIL clean_bit%0d got addr=%0d bit=%b expected addr=%0d bit=%b",
                                 nbits - 1, ram_address, pix_data, e.addr, e.b);
                    end
                end
            end
            if (done) ndone++;
        end
        checks++;
        if (addr_errs != 0 || nbits != 16 || ndone != 1) begin
            failures++;
            $display("FAIL clean_restart got addr_errs=%0d bits=%0d done=%0d expected 0/16/1",
                     addr_errs, nbits, ndone);
        end
    endtask

`ifdef SCAN_LOOP_EN
    task automatic test_loop();
        exp_t e;
        int nbits = 0, ndone = 0, done_cyc = -1;
        push_scan(9'd3, 2, 3);
        base = 9'd3; count = 10'd2; pix_ready = 1'b1; start = 1'b1;
        for (int cyc = 0; cyc < 115; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = (cyc == 80);
            if (pix_valid && pix_ready) begin
                nbits++; checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL loop_extra_bit got=%b expected none", pix_data);
                end else begin
                    e = sb.pop_front();
                    if ({ram_address, pix_data} !== {e.addr, e.b}) begin
                        failures++;
                        $display("FAIL loop_bit%0d got addr=%0d bit=%b expected addr=%0d bit=%b",
                                 nbits - 1, ram_address, pix_data, e.addr, e.b);
                    end
                end
            end
            if (done) begin ndone++; done_cyc = cyc; end
        end
        stop = 1'b0;
        checks++;
        if (nbits != 96 || ndone != 3 || done_cyc != 104 || busy !== 1'b0) begin
            failures++;
            $display("FAIL loop_passes got bits=%0d done=%0d last=%0d busy=%b expected 96/3/104/0",
                     nbits, ndone, done_cyc, busy);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
        test_reset();
        test_single_word();
        test_wrap();
        test_backpressure();
        test_count_zero_and_restart();
        test_reset_mid_scan();
`ifdef SCAN_LOOP_EN
        test_loop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
